// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-PC block.
//   ST_*               : fetch FSM state encodings (BOOT, REQ, HALT)
//   pc_src_e           : which source supplies the next PC
//   align_step         : PC increment in bytes for a given instruction alignment
//   target_misaligned  : alignment check on the low bits of a redirect target
package pc_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_BOOT = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ  = 2'd1;
  localparam logic [ST_W-1:0] ST_HALT = 2'd2;

  typedef enum logic [2:0] {
    SRC_HOLD  = 3'd0,
    SRC_PLUS  = 3'd1,
    SRC_PEND  = 3'd2,
    SRC_REDIR = 3'd3,
    SRC_TRAP  = 3'd4
  } pc_src_e;

  // Bytes per instruction step: 4 for 32-bit alignment, 2 for compressed.
  function automatic int unsigned align_step(input int unsigned ialign);
    return ialign / 8;
  endfunction

  // 16-bit alignment only requires bit 0 clear; 32-bit requires bits [1:0] clear.
  function automatic logic target_misaligned(input int unsigned ialign, input logic [1:0] low);
    if (ialign == 16) return low[0];
    return low != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-fetch bus between the fetch-PC block and imem / IF-ID register.
//   imem_req  : fetch request, address = pc
//   imem_gnt  : imem accepts the request this cycle
//   pc        : current fetch address
//   pc_plus   : pc + one instruction step
//   pc_valid  : request accepted this cycle
interface pc_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req;
  logic            imem_gnt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            pc_valid;

  modport master (output imem_req, pc, pc_plus, pc_valid, input imem_gnt);
  modport slave  (input imem_req, pc, pc_plus, pc_valid, output imem_gnt);

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC selection: pending-redirect buffer plus the priority mux
// trap > redirect > pending > hold > pc_plus.
//   update_en   : the PC register may change at this edge
//   latch_en    : a request is outstanding without grant; buffer incoming events
//   hold        : no fetch was accepted, keep the current PC as fallback
//   trap/trap_pc, redirect_ok/redirect_pc : redirect sources (redirect pre-qualified)
//   pc, pc_plus : current PC and its sequential successor
//   next_pc_c   : selected next PC (combinational)
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            update_en,
  input  logic            latch_en,
  input  logic            hold,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_ok,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus,
  output logic [XLEN-1:0] next_pc_c
);

  logic            pend_valid;
  logic            pend_trap;
  logic [XLEN-1:0] pend_pc;
  pc_src_e         src_c;

  // Pending buffer: a trap always overwrites, a redirect never displaces a buffered trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_trap  <= 1'b0;
      pend_pc    <= '0;
    end else if (update_en) begin
      pend_valid <= 1'b0;
      pend_trap  <= 1'b0;
    end else if (latch_en) begin
      if (trap) begin
        pend_valid <= 1'b1;
        pend_trap  <= 1'b1;
        pend_pc    <= trap_pc;
      end else if (redirect_ok && !pend_trap) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end
    end
  end

  // Source priority.
  always_comb begin
    src_c = SRC_PLUS;
    if (trap)             src_c = SRC_TRAP;
    else if (redirect_ok) src_c = SRC_REDIR;
    else if (pend_valid)  src_c = SRC_PEND;
    else if (hold)        src_c = SRC_HOLD;
  end

  always_comb begin
    next_pc_c = pc_plus;
    case (src_c)
      SRC_TRAP:  next_pc_c = trap_pc;
      SRC_REDIR: next_pc_c = redirect_pc;
      SRC_PEND:  next_pc_c = pend_pc;
      SRC_HOLD:  next_pc_c = pc;
      SRC_PLUS:  next_pc_c = pc_plus;
      default:   next_pc_c = pc_plus;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-PC unit: holds the fetch PC and issues it to imem over req/gnt, with stall,
// branch/trap redirect, halt, pending-redirect buffering, misaligned-target detection
// and an accepted-fetch counter.
//   clk, rst              : clock, synchronous active-high reset
//   stall, halt           : hazard hold / enter HALT once no request is ungranted
//   redirect, redirect_pc : branch/jump redirect from EX
//   trap, trap_pc         : exception/interrupt entry
//   misaligned            : one-cycle pulse for a misaligned redirect target
//   misaligned_pc         : last offending target
//   fetch_count           : accepted fetches, wrapping
//   bus                   : imem_req/imem_gnt handshake and pc/pc_plus/pc_valid
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     IALIGN       = 32,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              trap,
  input  logic [XLEN-1:0]   trap_pc,
  output logic              misaligned,
  output logic [XLEN-1:0]   misaligned_pc,
  output logic [CNT_W-1:0]  fetch_count,
  pc_fetch_unit_if.master   bus
);

  localparam int unsigned STEP = align_step(IALIGN);

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus_c;
  logic [XLEN-1:0] next_pc_c;
  logic            held_q;
  logic            req_c;
  logic            fire_c;
  logic            redir_bad_c;
  logic            redir_ok_c;
  logic            mis_evt_c;
  logic            update_en_c;
  logic            latch_en_c;

  assign pc_plus_c   = pc_q + XLEN'(STEP);
  // A held (ungranted) request ignores stall.
  assign req_c       = (state_q == ST_REQ) && (held_q || !stall);
  assign fire_c      = req_c && bus.imem_gnt;
  assign redir_bad_c = target_misaligned(IALIGN, redirect_pc[1:0]);
  assign redir_ok_c  = redirect && !redir_bad_c;
  // A trap in the same cycle takes precedence, so its redirect is simply dropped.
  assign mis_evt_c   = redirect && redir_bad_c && !trap && (state_q != ST_BOOT);
  // PC may move whenever no request is left ungranted (HALT never issues one).
  assign update_en_c = ((state_q == ST_REQ) && (!req_c || bus.imem_gnt)) || (state_q == ST_HALT);
  assign latch_en_c  = req_c && !bus.imem_gnt;

  assign bus.imem_req = req_c;
  assign bus.pc       = pc_q;
  assign bus.pc_plus  = pc_plus_c;
  assign bus.pc_valid = fire_c;

  pc_next_sel #(.XLEN(XLEN)) u_next_sel (
    .clk         (clk),
    .rst         (rst),
    .update_en   (update_en_c),
    .latch_en    (latch_en_c),
    .hold        (!req_c),
    .trap        (trap),
    .trap_pc     (trap_pc),
    .redirect_ok (redir_ok_c),
    .redirect_pc (redirect_pc),
    .pc          (pc_q),
    .pc_plus     (pc_plus_c),
    .next_pc_c   (next_pc_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ:  if (halt && !latch_en_c) state_d = ST_HALT;
      ST_HALT: if (trap || redir_ok_c) state_d = ST_REQ;
      default: state_d = ST_BOOT;
    endcase
  end

  // PC, handshake hold flag, misalignment report and fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      held_q        <= 1'b0;
      misaligned    <= 1'b0;
      misaligned_pc <= '0;
      fetch_count   <= '0;
    end else begin
      held_q     <= latch_en_c;
      misaligned <= mis_evt_c;
      if (update_en_c) pc_q <= next_pc_c;
      if (mis_evt_c)   misaligned_pc <= redirect_pc;
      if (fire_c)      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule
